// File: rtl/dec_mseq_correlator.sv
// Serial correlator for a 31-chip m-sequence: shifts one chip per clock and
// registers 2x the number of buffer bits that agree with the template.
module dec_mseq_correlator #(
  parameter int unsigned N = 31,
  parameter logic [N-1:0] TEMPLATE = 31'b0011001001111101110001010110100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         signal,
  output logic [7:0]   data,
  output logic [N-1:0] buff_wr
);

  logic [31:0] eq;
  logic [1:0]  sum1 [16];
  logic [2:0]  sum2 [8];
  logic [3:0]  sum3 [4];
  logic [4:0]  sum4 [2];
  logic [4:0]  match;

  // Pad to 32 leaves so the adder tree stays perfectly balanced.
  assign eq = {1'b0, ~(buff_wr ^ TEMPLATE)};

  for (genvar i = 0; i < 16; i++) begin : g_l1
    assign sum1[i] = {1'b0, eq[2*i]} + {1'b0, eq[2*i+1]};
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    assign sum2[i] = {1'b0, sum1[2*i]} + {1'b0, sum1[2*i+1]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    assign sum3[i] = {1'b0, sum2[2*i]} + {1'b0, sum2[2*i+1]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    assign sum4[i] = {1'b0, sum3[2*i]} + {1'b0, sum3[2*i+1]};
  end

  // At most 31 leaves are set, so the final sum fits in 5 bits.
  assign match = sum4[0] + sum4[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buff_wr <= '0;
      data    <= '0;
    end else begin
      buff_wr <= {signal, buff_wr[N-1:1]};
      data    <= {2'b00, match, 1'b0};
    end
  end

endmodule

// File: tb/tb_dec_mseq_correlator.sv
// Scoreboard bench for dec_mseq_correlator: stimulus pushes expected results,
// a monitor pops and compares one entry per clock.
module tb_dec_mseq_correlator;

  localparam logic [30:0] TMPL = 31'b0011001001111101110001010110100;

  logic        clk;
  logic        rst;
  logic        signal;
  logic [7:0]  data;
  logic [30:0] buff_wr;

  typedef struct {
    logic [30:0] buff;
    logic [7:0]  dat;
    bit          hd_en;
    logic [7:0]  hd;
    bit          hb_en;
    logic [30:0] hb;
  } exp_t;

  exp_t        sb[$];
  logic [30:0] mbuf;
  logic [30:0] t;
  int          total;
  int          bad;

  dec_mseq_correlator dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .data    (data),
    .buff_wr (buff_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one chip and record what the DUT must show after the next edge.
  task automatic step(input logic s, input bit hd_en = 0, input logic [7:0] hd = '0,
                      input bit hb_en = 0, input logic [30:0] hb = '0);
    exp_t e;
    @(negedge clk);
    signal = s;
    e.dat   = 8'(2 * $countones(~(mbuf ^ TMPL)));
    mbuf    = {s, mbuf[30:1]};
    e.buff  = mbuf;
    e.hd_en = hd_en;
    e.hd    = hd;
    e.hb_en = hb_en;
    e.hb    = hb;
    sb.push_back(e);
  endtask

  // Assert reset asynchronously mid-cycle, check it bites immediately, then release.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (data !== 8'd0) begin
      bad++;
      $display("FAIL async_rst_data: got %0d want 0", data);
    end
    total++;
    if (buff_wr !== 31'd0) begin
      bad++;
      $display("FAIL async_rst_buff: got %b want 0", buff_wr);
    end
    mbuf = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (data !== e.dat) begin
          bad++;
          $display("FAIL model_data: got %0d want %0d", data, e.dat);
        end
        total++;
        if (buff_wr !== e.buff) begin
          bad++;
          $display("FAIL model_buff: got %b want %b", buff_wr, e.buff);
        end
        if (e.hd_en) begin
          total++;
          if (data !== e.hd) begin
            bad++;
            $display("FAIL hand_data: got %0d want %0d", data, e.hd);
          end
        end
        if (e.hb_en) begin
          total++;
          if (buff_wr !== e.hb) begin
            bad++;
            $display("FAIL hand_buff: got %b want %b", buff_wr, e.hb);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total  = 0;
    bad    = 0;
    t      = TMPL;
    mbuf   = '0;
    rst    = 1'b1;
    signal = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (data !== 8'd0 || buff_wr !== 31'd0) begin
      bad++;
      $display("FAIL reset_state: got data=%0d buff=%b want 0/0", data, buff_wr);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b0, 1, 8'd30);

    // Aligned template, then cyclic feed
    for (int i = 0; i < 31; i++)
      step(t[i], i == 0, 8'd30, i == 30, TMPL);
    for (int k = 1; k <= 124; k++)
      step(t[(k-1) % 31], 1, ((k-1) % 31 == 0) ? 8'd62 : 8'd30, (k % 31) == 0, TMPL);

    // Constant input
    pulse_reset();
    for (int i = 1; i <= 40; i++)
      step(1'b1, i >= 32, 8'd32, i >= 31, {31{1'b1}});
    for (int i = 1; i <= 40; i++)
      step(1'b0, i >= 32, 8'd30, i >= 31, 31'd0);

    // Inverted template aligned
    for (int i = 0; i < 31; i++)
      step(~t[i], 0, 8'd0, i == 30, ~TMPL);
    step(~t[0], 1, 8'd0);

    // Reset partway through a template feed, then restart
    pulse_reset();
    for (int i = 0; i < 15; i++)
      step(t[i]);
    pulse_reset();
    for (int k = 1; k <= 32; k++)
      step(t[(k-1) % 31], (k == 1) || (k == 32), (k == 32) ? 8'd62 : 8'd30);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_mseq_correlator.md
Name: dec_mseq_correlator

Overview:
- Serial correlator/decoder for a 31-chip m-sequence.
- Shifts one received chip per clock into a 31-bit buffer.
- Compares the buffer bitwise against a fixed template and outputs a registered match score; the score peaks at 62 on exact alignment.
- Sits behind the chip-rate receiver front end. Downstream logic uses `data` and `buff_wr` for peak/sync detection.

Parameters:
- TEMPLATE, default 31'b0011001001111101110001010110100: reference m-sequence. Bit 0 is the first chip transmitted or received; bit 30 is the last.
- N, default 31: sequence length (buffer width). It is fixed at 31 for this block; `data` width is sized for 2*N ≤ 255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- signal  input  1  received chip, sampled every rising clk edge.
- data  output  8  registered correlation score = 2 × (number of buffer bits equal to TEMPLATE).
- buff_wr  output  31  current contents of the chip shift buffer (registered).

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately and holds while asserted): buff_wr = 0, data = 0.
- Shift buffer, every rising edge with rst=0:
  - buff_wr <= {signal, buff_wr[30:1]}.
  - The new chip enters bit 30; the oldest chip moves toward bit 0 and falls off bit 0.
  - After chips T[0], T[1] … T[30] are applied on consecutive edges, buff_wr == TEMPLATE exactly.
- Score:
  - match = popcount(~(buff_wr XOR TEMPLATE)), range 0..31.
  - data <= {2'b00, match, 1'b0}, i.e. 2×match, range 0..62. Equivalent to bipolar correlation + 31.
  - No overflow is possible; the upper bits are always 0.
- Latency:
  - data is registered from the buff_wr value present before the edge, so data lags buff_wr by one clock.
  - On the edge after buff_wr == TEMPLATE, data = 62.
- Expected values:
  - Periodic feed of the template: data = 62 once per 31 cycles and 30 on every other cycle (m-sequence autocorrelation −1 → 30).
  - Constant input: all zeros gives 30 (template has 15 zeros); all ones gives 32 (16 ones).
  - Inverted template aligned: 0.
- Reset mid-operation clears the buffer and score. After release, data first reflects the all-zero buffer (30), then follows the new chips. A full 31 fresh chips are needed before a true peak can occur.
- No handshake or enable: one chip is consumed on every clock.
- Implementation note: the popcount is to be built as a pipelined-free adder tree within one cycle (31 inputs, 5-bit result). An explicit balanced tree is preferred for timing.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> buff_wr = 0 and data = 0 immediately; release and hold signal=0 -> data = 30 one edge later.
- Aligned template: apply T[0]..T[30] on 31 edges -> buff_wr = 31'b0011001001111101110001010110100 after the 31st edge; data = 62 on the next edge.
- Cyclic template feed for 124 cycles -> data = 62 exactly every 31 cycles, all other cycles 30; buff_wr == TEMPLATE exactly one cycle before each peak.
- Constant input: 40 cycles of signal=1 -> buff_wr = all ones, data = 32; then 40 cycles of signal=0 -> data = 30.
- Inverted template aligned: feed ~T[0]..~T[30] -> buff_wr = ~TEMPLATE, next-cycle data = 0.
- Reset at cycle 15 of a template feed, then restart the feed -> no 62 until 31 full chips after release; peak at cycle 32 of the restarted feed.
